// File: rtl/seq_loader.sv
// Serial-to-parallel sample loader that feeds a layer, waits for its done strobe
// and presents the captured result through a valid/ready handshake.
module seq_loader #(
    parameter int N = 4,
    parameter int B = 4,
    parameter int M = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [B-1:0]     s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [N*B-1:0]   layer_data,
    output logic             layer_rst,
    input  logic             layer_done,
    input  logic [M-1:0]     layer_out,
    output logic [M-1:0]     res,
    output logic             res_valid,
    input  logic             res_ready
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        LOAD,
        RUN,
        SETTLE,
        OUT
    } state_t;

    state_t        state;
    logic [CW-1:0] wr_cnt;

    // s_ready and layer_rst are registered alongside the state so every output
    // is a flop; their values are a pure function of the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= LOAD;
            wr_cnt     <= '0;
            layer_data <= '0;
            res        <= '0;
            res_valid  <= 1'b0;
            s_ready    <= 1'b1;
            layer_rst  <= 1'b1;
        end else begin
            case (state)
                LOAD: begin
                    if (s_valid && s_ready) begin
                        layer_data[int'(wr_cnt)*B +: B] <= s_data;
                        if (wr_cnt == LAST) begin
                            wr_cnt    <= '0;
                            state     <= RUN;
                            s_ready   <= 1'b0;
                            layer_rst <= 1'b0;
                        end else begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (layer_done) begin
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    res       <= layer_out;
                    res_valid <= 1'b1;
                    layer_rst <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        s_ready   <= 1'b1;
                        state     <= LOAD;
                    end
                end
                default: begin
                    state     <= LOAD;
                    wr_cnt    <= '0;
                    res_valid <= 1'b0;
                    s_ready   <= 1'b1;
                    layer_rst <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_loader.sv
// Directed bench for seq_loader: cycle table for two inferences plus hand-written
// sequences for backpressure, spurious done, mid-run reset and back-to-back runs.
module tb_seq_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] layer_data;
    logic        layer_rst;
    logic        layer_done;
    logic [3:0]  layer_out = '0;
    logic [3:0]  res;
    logic        res_valid;
    logic        res_ready = 1'b0;

    logic [3:0]  layer_cnt = '0;
    logic        force_done = 1'b0;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // Behavioural layer: counts while released, done at count 3.
    always @(posedge clk) begin
        if (layer_rst) layer_cnt <= '0;
        else           layer_cnt <= layer_cnt + 4'd1;
    end
    assign layer_done = (layer_cnt == 4'd3) || force_done;

    seq_loader #(.N(4), .B(4), .M(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .layer_data (layer_data),
        .layer_rst  (layer_rst),
        .layer_done (layer_done),
        .layer_out  (layer_out),
        .res        (res),
        .res_valid  (res_valid),
        .res_ready  (res_ready)
    );

    typedef struct {
        logic        sv;
        logic [3:0]  sd;
        logic        rr;
        logic [3:0]  lo;
        logic        e_sr;
        logic        e_lr;
        logic        e_rv;
        logic [15:0] e_ld;
        logic [3:0]  e_res;
    } vec_t;

    vec_t tbl [23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    task automatic load4(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
        logic [3:0] smp [4];
        smp[0] = a; smp[1] = b; smp[2] = c; smp[3] = d;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = smp[k];
        end
    endtask

    // Counts negedges after the last sample drive until res_valid, bounded.
    task automatic wait_res(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            s_valid = 1'b0;
            cycles++;
        end while (!res_valid && cycles <= 20);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        //           sv  sd    rr  lo    sr  lr  rv  ld        res
        tbl[0]  = '{1'b1, 4'h1, 1'b1, 4'h9, 1'b1, 1'b1, 1'b0, 16'h0000, 4'h0};
        tbl[1]  = '{1'b1, 4'h2, 1'b1, 4'h9, 1'b1, 1'b1, 1'b0, 16'h0001, 4'h0};
        tbl[2]  = '{1'b1, 4'h3, 1'b1, 4'h9, 1'b1, 1'b1, 1'b0, 16'h0021, 4'h0};
        tbl[3]  = '{1'b1, 4'h4, 1'b1, 4'h9, 1'b1, 1'b1, 1'b0, 16'h0321, 4'h0};
        for (int i = 4; i <= 8; i++)
            tbl[i] = '{1'b0, 4'h0, 1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 16'h4321, 4'h0};
        tbl[9]  = '{1'b0, 4'h0, 1'b1, 4'h9, 1'b0, 1'b1, 1'b1, 16'h4321, 4'h9};
        tbl[10] = '{1'b1, 4'hA, 1'b1, 4'h6, 1'b1, 1'b1, 1'b0, 16'h4321, 4'h9};
        tbl[11] = '{1'b0, 4'hF, 1'b1, 4'h6, 1'b1, 1'b1, 1'b0, 16'h432A, 4'h9};
        tbl[12] = '{1'b1, 4'hB, 1'b1, 4'h6, 1'b1, 1'b1, 1'b0, 16'h432A, 4'h9};
        tbl[13] = '{1'b0, 4'h7, 1'b1, 4'h6, 1'b1, 1'b1, 1'b0, 16'h43BA, 4'h9};
        tbl[14] = '{1'b1, 4'hC, 1'b1, 4'h6, 1'b1, 1'b1, 1'b0, 16'h43BA, 4'h9};
        tbl[15] = '{1'b0, 4'h0, 1'b1, 4'h6, 1'b1, 1'b1, 1'b0, 16'h4CBA, 4'h9};
        tbl[16] = '{1'b1, 4'hD, 1'b1, 4'h6, 1'b1, 1'b1, 1'b0, 16'h4CBA, 4'h9};
        for (int i = 17; i <= 21; i++)
            tbl[i] = '{1'b0, 4'h0, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0, 16'hDCBA, 4'h9};
        tbl[22] = '{1'b0, 4'h0, 1'b0, 4'h6, 1'b0, 1'b1, 1'b1, 16'hDCBA, 4'h6};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_s_ready",   s_ready,    1);
        check("rst_layer_rst", layer_rst,  1);
        check("rst_res_valid", res_valid,  0);
        check("rst_layer_data", layer_data, 0);
        check("rst_res",       res,        0);
        rst = 1'b1;

        // Two inferences cycle by cycle
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            check($sformatf("row%0d_s_ready", i),    s_ready,    tbl[i].e_sr);
            check($sformatf("row%0d_layer_rst", i),  layer_rst,  tbl[i].e_lr);
            check($sformatf("row%0d_res_valid", i),  res_valid,  tbl[i].e_rv);
            check($sformatf("row%0d_layer_data", i), layer_data, tbl[i].e_ld);
            check($sformatf("row%0d_res", i),        res,        tbl[i].e_res);
            s_valid   = tbl[i].sv;
            s_data    = tbl[i].sd;
            res_ready = tbl[i].rr;
            layer_out = tbl[i].lo;
        end

        // Backpressure in OUT, with spurious done and changing layer_out
        for (int i = 0; i < 10; i++) begin
            layer_out  = 4'(i);
            force_done = i[0];
            @(negedge clk);
            check("hold_res_valid", res_valid, 1);
            check("hold_res",       res,       4'h6);
            check("hold_s_ready",   s_ready,   0);
            check("hold_layer_rst", layer_rst, 1);
        end
        force_done = 1'b0;
        res_ready  = 1'b1;
        @(negedge clk);
        check("release_s_ready",   s_ready,   1);
        check("release_res_valid", res_valid, 0);
        check("release_res_keep",  res,       4'h6);
        res_ready = 1'b0;

        // Spurious done in LOAD is ignored
        layer_out  = 4'b1010;
        force_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("load_done_s_ready",   s_ready,    1);
            check("load_done_layer_rst", layer_rst,  1);
            check("load_done_data",      layer_data, 16'hDCBA);
        end
        force_done = 1'b0;
        layer_out  = 4'b0110;
        load4(4'h8, 4'h7, 4'h6, 4'h5);
        wait_res(cyc);
        check("valid_run_latency", cyc, 6);
        check("valid_run_res",     res, 4'b0110);
        check("valid_run_data",    layer_data, 16'h5678);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("valid_run_back_load", s_ready, 1);

        // Reset during RUN after two layer cycles
        load4(4'h1, 4'h1, 4'h1, 4'h1);
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_in_run", s_ready, 0);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_layer_data", layer_data, 0);
        check("mid_rst_res_valid",  res_valid,  0);
        check("mid_rst_layer_rst",  layer_rst,  1);
        check("mid_rst_s_ready",    s_ready,    1);
        @(negedge clk);
        rst = 1'b1;
        layer_out = 4'h5;
        load4(4'h5, 4'h6, 4'h7, 4'h8);
        wait_res(cyc);
        check("post_rst_latency", cyc, 6);
        check("post_rst_data",    layer_data, 16'h8765);
        check("post_rst_res",     res, 4'h5);

        // Back-to-back inferences with res_ready tied high
        res_ready = 1'b1;
        @(negedge clk);
        check("b2b0_res_valid_low", res_valid, 0);
        layer_out = 4'h3;
        load4(4'h9, 4'hA, 4'hB, 4'hC);
        wait_res(cyc);
        check("b2b1_latency", cyc, 6);
        check("b2b1_res",     res, 4'h3);
        @(negedge clk);
        check("b2b1_one_pulse", res_valid, 0);
        layer_out = 4'hC;
        load4(4'h2, 4'h4, 4'h6, 4'h8);
        wait_res(cyc);
        check("b2b2_latency", cyc, 6);
        check("b2b2_res",     res, 4'hC);
        check("b2b2_data",    layer_data, 16'h8642);
        @(negedge clk);
        check("b2b2_one_pulse", res_valid, 0);
        check("b2b2_s_ready",   s_ready,   1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seq_loader.md
SEQ_LOADER -- requirements
Module: seq_loader

Interface
REQ-001 Parameter N, default 4: number of input slots per inference; N >= 2.
REQ-002 Parameter B, default 4: width of one input slot.
REQ-003 Parameter M, default 4: width of the layer result.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low.
REQ-006 s_data  input  B  input sample.
REQ-007 s_valid  input  1  s_data valid.
REQ-008 s_ready  output  1  loader accepts a sample this cycle.
REQ-009 layer_data  output  N*B  packed layer input; slot k at bits [k*B +: B].
REQ-010 layer_rst  output  1  active-high reset to the layer; holds its counter at 0.
REQ-011 layer_done  input  1  layer's last-slot indication.
REQ-012 layer_out  input  M  layer result bits.
REQ-013 res  output  M  captured result.
REQ-014 res_valid  output  1  res valid.
REQ-015 res_ready  input  1  downstream accepts res.

Function
REQ-016 The block SHALL implement four states: LOAD, RUN, SETTLE, OUT.
REQ-017 LOAD: s_ready=1, layer_rst=1, res_valid=0.
REQ-018 LOAD: on s_valid&&s_ready, s_data SHALL be written to slot wr_cnt of layer_data and wr_cnt SHALL increment.
REQ-019 LOAD: the handshake at wr_cnt==N-1 SHALL write the last slot, clear wr_cnt to 0 and enter RUN next cycle.
REQ-020 s_valid low in LOAD SHALL leave slots and wr_cnt unchanged; no timeout.
REQ-021 RUN: s_ready=0, layer_rst=0; layer_data SHALL be held stable in every state except during LOAD writes.
REQ-022 RUN: first cycle with layer_done=1 SHALL transition to SETTLE; layer_rst stays 0 in that transition cycle.
REQ-023 SETTLE (exactly one cycle): layer_rst=0; res SHALL register layer_out at the SETTLE-exit edge, res_valid set to 1, next state OUT.
REQ-024 OUT: res_valid=1, res stable, s_ready=0, layer_rst=1.
REQ-025 OUT: on res_valid&&res_ready, res_valid SHALL clear and state SHALL return to LOAD next cycle; res keeps its last value.
REQ-026 res_ready asserted outside OUT SHALL have no effect.
REQ-027 Latency: last sample accepted at edge t, RUN begins t+1; with the layer signalling done N-1 cycles later, res_valid rises N+1 cycles after t.
REQ-028 s_data and layer_out SHALL be unsigned bit vectors, stored without arithmetic; wr_cnt width SHALL be clog2(N).
REQ-029 layer_done asserted in LOAD, SETTLE or OUT SHALL be ignored.

Reset
REQ-030 rst low SHALL asynchronously force: state LOAD, wr_cnt=0, layer_data=0, res=0, res_valid=0; layer_rst=1 and s_ready=1 combinationally follow.
REQ-031 rst low mid-LOAD, mid-RUN or in OUT SHALL discard partial samples and any pending result; no res_valid pulse after release.
REQ-032 After rst rises, the first sample SHALL be accepted on the first clk edge with s_valid=1.

Verification (N=4, B=4, M=4, behavioural layer model with done at count 3)
REQ-033 Samples 1,2,3,4 back-to-back -> layer_data=16'h4321, RUN 1 cycle after last accept, res_valid 5 cycles after last accept.
REQ-034 s_valid toggling 1,0,1,0,... over samples A,B,C,D -> layer_data=16'hDCBA, wr_cnt advances only on handshakes, s_ready stays 1.
REQ-035 res_ready held 0 for 10 cycles in OUT -> res and res_valid constant, s_ready=0, layer_rst=1; res_ready=1 -> LOAD next cycle.
REQ-036 rst low during RUN after 2 layer cycles -> layer_data=0, res_valid=0, layer_rst=1 immediately; next 4 samples load normally.
REQ-037 layer_out=4'b1010 while layer_done pulses in LOAD -> no state change; later valid run with layer_out=4'b0110 -> res=4'b0110.
REQ-038 Two back-to-back inferences with res_ready tied 1 -> res_valid one cycle per inference, second result independent of first.
